// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Holds the scan-state type, the blink-phase encoding and the
// active-low segment patterns ({g,f,e,d,c,b,a}, 0 = lit).
package seg_scan_pkg;

  // One state per driven digit; encoding 2'd3 is unused and recovers to DIG0
  typedef enum logic [1:0] {
    DIG0 = 2'd0,  // ones
    DIG1 = 2'd1,  // tens
    DIG2 = 2'd2   // hundreds
  } scan_state_t;

  // Alarm blink phase
  localparam logic PHASE_VISIBLE = 1'b0;
  localparam logic PHASE_HIDDEN  = 1'b1;

  // Active-low segment patterns for decimal digits 0..9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-BCD codes show a dash (segment g only)
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Anode patterns, active-low; an[3] is never driven
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// Purely combinational BCD to active-low seven-segment decoder.
// Codes 10..15 decode to a dash.
module bcd_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup; anything outside 0..9 becomes a dash
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_DIGIT[0];
      4'd1:    seg_o = SEG_DIGIT[1];
      4'd2:    seg_o = SEG_DIGIT[2];
      4'd3:    seg_o = SEG_DIGIT[3];
      4'd4:    seg_o = SEG_DIGIT[4];
      4'd5:    seg_o = SEG_DIGIT[5];
      4'd6:    seg_o = SEG_DIGIT[6];
      4'd7:    seg_o = SEG_DIGIT[7];
      4'd8:    seg_o = SEG_DIGIT[8];
      4'd9:    seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit time-multiplexed driver for a 4-anode common-anode
// seven-segment display. Digits are snapshotted once per frame,
// leading zeros are blanked and the display flashes while alarm is high.
// Optional heartbeat decimal point on the ones digit: SEG_SCAN_HEARTBEAT_EN.
//
// Outputs are registered from next-state values so that an/seg/dp
// change in the cycle right after the prescaler tick, together with
// the scan state itself.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,  // clk cycles per digit slot, >= 2
  parameter int BLINK_FRAMES = 64      // frames per blink half-period, >= 1
) (
  input  logic       clk,
  input  logic       reset,        // asynchronous, active-low
  input  logic [3:0] value_three,  // hundreds
  input  logic [3:0] value_two,    // tens
  input  logic [3:0] value_one,    // ones
  input  logic       alarm,
  input  logic       sec_timer,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  scan_state_t   state_q, state_d;
  logic [3:0]    sh_one_q, sh_one_d;
  logic [3:0]    sh_two_q, sh_two_d;
  logic [3:0]    sh_three_q, sh_three_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_tick;
  logic          hidden;
  logic [3:0]    digit_sel;
  logic [6:0]    digit_seg;
  logic          hb_d;

  // Prescaler: one tick per digit slot
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Scan FSM next state; unused encoding recovers to DIG0 immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIG0:    if (tick) state_d = DIG1;
      DIG1:    if (tick) state_d = DIG2;
      DIG2:    if (tick) state_d = DIG0;
      default: state_d = DIG0;
    endcase
    frame_tick = tick && (state_q == DIG2);
  end

  // Snapshot the inputs at the frame boundary so one frame never mixes values
  always_comb begin
    sh_one_d   = sh_one_q;
    sh_two_d   = sh_two_q;
    sh_three_d = sh_three_q;
    if (frame_tick) begin
      sh_one_d   = value_one;
      sh_two_d   = value_two;
      sh_three_d = value_three;
    end
  end

  // Blink timing only runs while alarm is high; otherwise held at VISIBLE/0
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (!alarm) begin
      frame_d = '0;
      phase_d = PHASE_VISIBLE;
    end else if (frame_tick) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    hidden = alarm && (phase_d == PHASE_HIDDEN);
  end

  // Select the shadow digit for the slot being shown next
  always_comb begin
    case (state_d)
      DIG0:    digit_sel = sh_one_d;
      DIG1:    digit_sel = sh_two_d;
      default: digit_sel = sh_three_d;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (digit_seg)
  );

`ifdef SEG_SCAN_HEARTBEAT_EN
  logic hb_q;

  // Heartbeat toggles once per second pulse
  always_comb begin
    hb_d = hb_q ^ sec_timer;
  end

  // Heartbeat register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hb_q <= 1'b0;
    else        hb_q <= hb_d;
  end
`else
  logic unused_sec_timer;

  // Without the heartbeat the second pulse has no effect
  always_comb begin
    hb_d = 1'b0;
  end
  assign unused_sec_timer = sec_timer ^ hb_d;
`endif

  // Output decode: one anode at most, blanking and alarm hide applied here
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!hidden) begin
      case (state_d)
        DIG0: begin
          an_d  = AN_ONES;
          seg_d = digit_seg;
`ifdef SEG_SCAN_HEARTBEAT_EN
          dp_d  = ~hb_d;
`endif
        end
        DIG1: begin
          if ((sh_three_d != 4'd0) || (sh_two_d != 4'd0)) begin
            an_d  = AN_TENS;
            seg_d = digit_seg;
          end
        end
        DIG2: begin
          if (sh_three_d != 4'd0) begin
            an_d  = AN_HUND;
            seg_d = digit_seg;
          end
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q      <= '0;
      state_q    <= DIG0;
      sh_one_q   <= 4'd0;
      sh_two_q   <= 4'd0;
      sh_three_q <= 4'd0;
      frame_q    <= '0;
      phase_q    <= PHASE_VISIBLE;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      pre_q      <= pre_d;
      state_q    <= state_d;
      sh_one_q   <= sh_one_d;
      sh_two_q   <= sh_two_d;
      sh_three_q <= sh_three_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
